// File: rtl/gf_square_sched.sv
// Shared iterative GF(2^NUM_BITS) squaring engine: computes A^(2^k) by k passes
// through one combinational squarer, arbitrated round-robin between two requesters.

module gf_Square #(
    parameter int NUM_BITS = 163
) (
    input  logic [NUM_BITS:0] a,
    output logic [NUM_BITS:0] sq
);

    // Spread bits (squaring in GF(2) is bit interleaving) then fold high terms
    // down with x^163 = x^7 + x^6 + x^3 + 1, highest degree first.
    function automatic logic [NUM_BITS:0] sq_mod(input logic [NUM_BITS:0] v);
        logic [2*NUM_BITS:0] p;
        logic                b;
        p = '0;
        for (int i = 0; i <= NUM_BITS; i++) begin
            p[2*i] = v[i];
        end
        for (int i = 2*NUM_BITS; i >= NUM_BITS; i--) begin
            b                  = p[i];
            p[i]               = 1'b0;
            p[i-NUM_BITS]      = p[i-NUM_BITS]     ^ b;
            p[i-NUM_BITS+3]    = p[i-NUM_BITS+3]   ^ b;
            p[i-NUM_BITS+6]    = p[i-NUM_BITS+6]   ^ b;
            p[i-NUM_BITS+7]    = p[i-NUM_BITS+7]   ^ b;
        end
        return p[NUM_BITS:0];
    endfunction

    // Pure combinational squarer.
    always_comb begin
        sq = sq_mod(a);
    end

endmodule

module gf_square_sched #(
    parameter int NUM_BITS = 163,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [1:0]          req,
    input  logic [NUM_BITS:0]   op_a0,
    input  logic [NUM_BITS:0]   op_a1,
    input  logic [CNT_BITS-1:0] cnt0,
    input  logic [CNT_BITS-1:0] cnt1,
    output logic [1:0]          gnt,
    output logic                busy,
    output logic [1:0]          done,
    output logic [NUM_BITS:0]   result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              r_state, w_state;
    logic [NUM_BITS:0]   r_acc, w_acc;
    logic [CNT_BITS-1:0] r_cnt, w_cnt;
    logic [1:0]          r_gnt, w_gnt;
    logic [1:0]          r_done, w_done;
    logic                r_busy, w_busy;
    logic [NUM_BITS:0]   r_result, w_result;
    logic                r_ptr, w_ptr;   // index of last-served requester
    logic                w_sel;
    logic [NUM_BITS:0]   w_sq;

    gf_Square #(.NUM_BITS(NUM_BITS)) u_sq (
        .a  (r_acc),
        .sq (w_sq)
    );

    // Next-state and next-output computation; all outputs come from registers.
    always_comb begin
        w_state  = r_state;
        w_acc    = r_acc;
        w_cnt    = r_cnt;
        w_gnt    = r_gnt;
        w_done   = 2'b00;
        w_busy   = r_busy;
        w_result = r_result;
        w_ptr    = r_ptr;
        w_sel    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req != 2'b00) begin
                    if (req == 2'b11) begin
                        w_sel = ~r_ptr;
                    end else begin
                        w_sel = req[1];
                    end
                    w_gnt  = w_sel ? 2'b10 : 2'b01;
                    w_ptr  = w_sel;
                    w_acc  = w_sel ? op_a1 : op_a0;
                    w_cnt  = w_sel ? cnt1  : cnt0;
                    w_busy = 1'b1;
                    if (w_cnt == {CNT_BITS{1'b0}}) begin
                        w_state  = DONE;
                        w_done   = w_gnt;
                        w_result = w_acc;
                    end else begin
                        w_state  = RUN;
                    end
                end else begin
                    w_gnt  = 2'b00;
                    w_busy = 1'b0;
                end
            end
            RUN: begin
                w_acc = w_sq;
                w_cnt = r_cnt - CNT_BITS'(1);
                if (r_cnt == CNT_BITS'(1)) begin
                    w_state  = DONE;
                    w_done   = r_gnt;
                    w_result = w_sq;
                end else begin
                    w_state  = RUN;
                end
            end
            DONE: begin
                w_state = IDLE;
                w_gnt   = 2'b00;
                w_busy  = 1'b0;
            end
            default: begin
                w_state = IDLE;
                w_gnt   = 2'b00;
                w_busy  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any job without a done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_busy   <= 1'b0;
            r_result <= '0;
            r_ptr    <= 1'b1;
        end else begin
            r_state  <= w_state;
            r_acc    <= w_acc;
            r_cnt    <= w_cnt;
            r_gnt    <= w_gnt;
            r_done   <= w_done;
            r_busy   <= w_busy;
            r_result <= w_result;
            r_ptr    <= w_ptr;
        end
    end

    assign gnt    = r_gnt;
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_gf_square_sched.sv
// Directed, table-driven bench for gf_square_sched with hand-computed field results.

module tb_gf_square_sched;

    localparam int NB = 163;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [1:0]    req;
    logic [NB:0]   op_a0, op_a1;
    logic [CB-1:0] cnt0, cnt1;
    logic [1:0]    gnt, done;
    logic          busy;
    logic [NB:0]   result;

    int checks   = 0;
    int failures = 0;

    gf_square_sched #(.NUM_BITS(NB), .CNT_BITS(CB)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .req    (req),
        .op_a0  (op_a0),
        .op_a1  (op_a1),
        .cnt0   (cnt0),
        .cnt1   (cnt1),
        .gnt    (gnt),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    rq;
        logic [NB:0]   a0;
        logic [NB:0]   a1;
        logic [CB-1:0] c0;
        logic [CB-1:0] c1;
        int            lat;
        logic [NB:0]   res;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [NB:0] act, input logic [NB:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply one single-requester vector from an IDLE negedge, wait for done.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc    = 0;
        int busy_n = 0;
        bit seen   = 1'b0;
        req   = v.rq;
        op_a0 = v.a0;
        op_a1 = v.a1;
        cnt0  = v.c0;
        cnt1  = v.c1;
        while (!seen && cyc < 400) begin
            cycle();
            cyc++;
            if (cyc == 1) chk($sformatf("v%0d_gnt", idx), NB'(gnt), NB'(v.rq));
            if (busy) busy_n++;
            if (done != 2'b00) begin
                seen = 1'b1;
                chk($sformatf("v%0d_done", idx), NB'(done), NB'(v.rq));
                chk($sformatf("v%0d_result", idx), result, v.res);
                chk($sformatf("v%0d_latency", idx), NB'(cyc), NB'(v.lat));
                req = 2'b00;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL v%0d_timeout: no done after %0d cycles, required %0d", idx, cyc, v.lat);
            req = 2'b00;
        end
        chk($sformatf("v%0d_busy_cycles", idx), NB'(busy_n), NB'(v.lat));
        cycle();
        chk($sformatf("v%0d_idle_busy", idx), NB'(busy), '0);
        chk($sformatf("v%0d_idle_gnt", idx), NB'(gnt), '0);
    endtask

    initial begin
        logic [NB:0] t;
        logic [1:0]  exp_d;

        vecs[0] = '{2'b01, 164'h2,  164'h0, 8'd1,   8'd0, 2,   164'h4};
        vecs[1] = '{2'b01, 164'h2,  164'h0, 8'd3,   8'd0, 4,   164'h100};
        t = '0; t[82] = 1'b1;
        vecs[2] = '{2'b10, 164'h0,  t,      8'd0,   8'd1, 2,   164'h192};
        vecs[3] = '{2'b10, 164'h0,  164'h5A, 8'd0,  8'd0, 1,   164'h5A};
        vecs[4] = '{2'b01, 164'h3,  164'h0, 8'd2,   8'd0, 3,   164'h11};
        t = '0; t[100] = 1'b1;
        vecs[5] = '{2'b01, t,       164'h0, 8'd1,   8'd0, 2,   164'h192000000000};
        t = '0; t[162] = 1'b1;
        vecs[6] = '{2'b10, 164'h0,  t,      8'd0,   8'd1, 2,   164'h0};
        vecs[6].res = 164'h1422;
        vecs[6].res[161] = 1'b1;
        vecs[7] = '{2'b01, 164'h1,  164'h0, 8'd255, 8'd0, 256, 164'h1};

        n_rst = 1'b0; req = 2'b00; op_a0 = '0; op_a1 = '0; cnt0 = '0; cnt1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",    NB'(gnt),  '0);
        chk("rst_busy",   NB'(busy), '0);
        chk("rst_done",   NB'(done), '0);
        chk("rst_result", result,    '0);
        n_rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Both requesters held from reset: grants alternate 0,1,0 every 4 cycles.
        n_rst = 1'b0;
        req = 2'b11; op_a0 = 164'h2; op_a1 = 164'h3; cnt0 = 8'd2; cnt1 = 8'd2;
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            cycle();
            exp_d = (c == 3 || c == 11) ? 2'b01 : ((c == 7) ? 2'b10 : 2'b00);
            chk($sformatf("rr_done_c%0d", c), NB'(done), NB'(exp_d));
            if (exp_d == 2'b01) chk($sformatf("rr_res_c%0d", c), result, 164'h10);
            if (exp_d == 2'b10) chk($sformatf("rr_res_c%0d", c), result, 164'h11);
        end
        req = 2'b00;
        cycle();

        // Reset in the middle of a k=5 job.
        req = 2'b01; op_a0 = 164'h2; cnt0 = 8'd5;
        cycle(); cycle(); cycle();
        chk("mid_busy_before", NB'(busy), NB'(1));
        n_rst = 1'b0;
        #1;
        chk("mid_rst_gnt",    NB'(gnt),  '0);
        chk("mid_rst_busy",   NB'(busy), '0);
        chk("mid_rst_result", result,    '0);
        req = 2'b00;
        exp_d = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_d = exp_d | done;
        end
        chk("mid_rst_no_done", NB'(exp_d), '0);
        n_rst = 1'b1;
        @(negedge clk);
        run_vec(vecs[0], 8);

        // Operand/count changes while granted are ignored; requester 1 waits.
        req = 2'b01; op_a0 = 164'h2; cnt0 = 8'd3; op_a1 = 164'h5A; cnt1 = 8'd0;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            exp_d = (c == 4) ? 2'b01 : ((c == 6) ? 2'b10 : 2'b00);
            chk($sformatf("hold_done_c%0d", c), NB'(done), NB'(exp_d));
            if (c == 1) begin
                op_a0 = 164'hFFFF; cnt0 = 8'd7; req = 2'b11;
            end
            if (c == 4) begin
                chk("hold_res0", result, 164'h100);
                req = 2'b10;
            end
            if (c == 5) chk("hold_gnt_idle", NB'(gnt), '0);
            if (c == 6) begin
                chk("hold_res1", result, 164'h5A);
                chk("hold_gnt1", NB'(gnt), NB'(2'b10));
                req = 2'b00;
            end
        end
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
